ram_port_arbiter: RTL and testbench

- Shares one single-port frame RAM (the 8-bit x 76800 image store) between three requesters: port 0 = UART RX writer, port 1 = processing core, port 2 = UART TX reader.
- Sits between those masters and the RAM instance, replacing per-state direct RAM driving in the top-level sequencer.
- Round-robin arbitration, optional burst lock, 1- or 2-cycle read-return pipeline, and out-of-range address trapping.

---
 rtl/ram_port_arbiter_pkg.sv | 27 ++
 rtl/ram_port_arbiter_if.sv | 40 ++++
 rtl/ram_port_arbiter_rr_pick3.sv | 34 +++
 rtl/ram_port_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// ram_arb_pkg : shared constants, FSM encoding and helpers for ram_port_arbiter
// Rev 1.0
// ============================================================================
package ram_arb_pkg;

  localparam int N_PORTS  = 3;
  localparam int P_RX     = 0;
  localparam int P_CORE   = 1;
  localparam int P_TX     = 2;
  localparam int LOCK_MAX = 256;
  localparam int LOCK_CW  = $clog2(LOCK_MAX);

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [N_PORTS-1:0] oh);
    if (oh[P_TX])        return 2'(P_TX);
    else if (oh[P_CORE]) return 2'(P_CORE);
    else                 return 2'(P_RX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// ram_port_arbiter_if : requester-side and RAM-side bus of the frame RAM arbiter
// Rev 1.0
// ============================================================================
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 17
);
  logic [N_PORTS-1:0]    req_i;
  logic [N_PORTS-1:0]    we_i;
  logic [N_PORTS-1:0]    lock_i;
  logic [N_PORTS*AW-1:0] addr_i;
  logic [N_PORTS*DW-1:0] wdata_i;
  logic [N_PORTS-1:0]    gnt_o;
  logic [N_PORTS-1:0]    rvalid_o;
  logic [DW-1:0]         rdata_o;
  logic [N_PORTS-1:0]    err_o;
  logic                  ram_en_o;
  logic                  ram_we_o;
  logic [AW-1:0]         ram_addr_o;
  logic [DW-1:0]         ram_wdata_o;
  logic [DW-1:0]         ram_rdata_i;
  logic                  busy_o;

  modport slave (
    input  req_i, we_i, lock_i, addr_i, wdata_i, ram_rdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o, ram_en_o, ram_we_o,
           ram_addr_o, ram_wdata_o, busy_o
  );

  modport master (
    output req_i, we_i, lock_i, addr_i, wdata_i, ram_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, ram_en_o, ram_we_o,
           ram_addr_o, ram_wdata_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/ram_port_arbiter_rr_pick3.sv
`default_nettype none
// ============================================================================
// rr_pick3 : 3-way round-robin selector, search order ptr+1, ptr+2, ptr
// Rev 1.0
// ============================================================================
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = 3'b000;
    case (ptr)
      2'd0: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      2'd1: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// ram_port_arbiter : round-robin share of one single-port frame RAM among three
//                    requesters, with burst lock and out-of-range trapping
// Rev 1.0
// ============================================================================
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DW     = 8,
  parameter int AW     = 17,
  parameter int DEPTH  = 76800,
  parameter int RD_LAT = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  ram_port_arbiter_if.slave        bus
);

  arb_state_e               state_q, state_d;
  logic [1:0]               ptr_q, ptr_d;
  logic [1:0]               owner_q, owner_d;
  logic [LOCK_CW-1:0]       cnt_q, cnt_d;

  logic [N_PORTS-1:0]       eligible, pick, gnt;
  logic [1:0]               win_idx;
  logic [AW-1:0]            win_addr;
  logic [DW-1:0]            win_wdata;
  logic                     win_we, win_lock, win_oor, any_gnt;

  logic                     en_q, we_q;
  logic [AW-1:0]            addr_q;
  logic [DW-1:0]            wdata_q;
  logic [N_PORTS-1:0]       tag_q [RD_LAT+1];
  logic [RD_LAT:0]          oor_q;
  logic                     tag_any;
  logic [N_PORTS-1:0]       valid_out;

  always_comb begin
    eligible = bus.req_i;
    if (state_q == LOCKED) eligible = bus.req_i & (3'b001 << owner_q);
  end

  rr_pick3 u_pick (
    .req (eligible),
    .ptr (ptr_q),
    .gnt (pick)
  );

  assign gnt       = pick & {N_PORTS{~rst_i}};
  assign any_gnt   = |gnt;
  assign win_idx   = onehot_to_idx(pick);
  assign win_addr  = bus.addr_i[int'(win_idx)*AW +: AW];
  assign win_wdata = bus.wdata_i[int'(win_idx)*DW +: DW];
  assign win_we    = bus.we_i[win_idx];
  assign win_lock  = bus.lock_i[win_idx];
  assign win_oor   = {1'b0, win_addr} >= (AW+1)'(DEPTH);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (any_gnt) ptr_d = win_idx;
    case (state_q)
      ARB: begin
        if (any_gnt && win_lock) begin
          state_d = LOCKED;
          owner_d = win_idx;
          cnt_d   = LOCK_CW'(1);
        end
      end
      LOCKED: begin
        // The grant that reaches LOCK_MAX ends the burst so other ports get a turn
        if (any_gnt) begin
          if (!win_lock || cnt_q == LOCK_CW'(LOCK_MAX-1)) state_d = ARB;
          else                                              cnt_d   = cnt_q + 1'b1;
        end else if (!bus.req_i[owner_q] && !bus.lock_i[owner_q]) begin
          state_d = ARB;
          ptr_d   = owner_q;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB;
      // Last winner taken as port 2 so port 0 leads the first search
      ptr_q   <= 2'(N_PORTS-1);
      owner_q <= 2'd0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      oor_q   <= '0;
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      en_q    <= any_gnt && !win_oor;
      if (any_gnt) begin
        we_q    <= win_we;
        addr_q  <= win_addr;
        wdata_q <= win_wdata;
      end
      tag_q[0] <= (any_gnt && !win_we) ? gnt : '0;
      oor_q[0] <= any_gnt && win_oor;
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
        oor_q[i] <= oor_q[i-1];
      end
    end
  end

  always_comb begin
    tag_any = 1'b0;
    for (int i = 0; i <= RD_LAT; i++) tag_any = tag_any | (|tag_q[i]);
  end

  assign valid_out       = tag_q[RD_LAT] & {N_PORTS{~rst_i}};
  assign bus.gnt_o       = gnt;
  assign bus.err_o       = gnt & {N_PORTS{win_oor}};
  assign bus.rvalid_o    = valid_out;
  assign bus.rdata_o     = (|valid_out && !oor_q[RD_LAT]) ? bus.ram_rdata_i : '0;
  assign bus.ram_en_o    = en_q & ~rst_i;
  assign bus.ram_we_o    = we_q & ~rst_i;
  assign bus.ram_addr_o  = addr_q;
  assign bus.ram_wdata_o = wdata_q;
  assign bus.busy_o      = ((state_q == LOCKED) | tag_any) & ~rst_i;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ram_port_arbiter : directed bench, RD_LAT=1 and RD_LAT=2 instances in parallel
// Rev 1.0
// ============================================================================
module tb_ram_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 17;

  logic clk, rst;
  int   errors = 0;
  int   checks = 0;

  ram_port_arbiter_if #(.DW(DW), .AW(AW)) bus1 ();
  ram_port_arbiter_if #(.DW(DW), .AW(AW)) bus2 ();

  ram_port_arbiter #(.DW(DW), .AW(AW), .DEPTH(76800), .RD_LAT(1)) dut1 (
    .clk_i (clk), .rst_i (rst), .bus (bus1)
  );
  ram_port_arbiter #(.DW(DW), .AW(AW), .DEPTH(76800), .RD_LAT(2)) dut2 (
    .clk_i (clk), .rst_i (rst), .bus (bus2)
  );

  assign bus2.req_i   = bus1.req_i;
  assign bus2.we_i    = bus1.we_i;
  assign bus2.lock_i  = bus1.lock_i;
  assign bus2.addr_i  = bus1.addr_i;
  assign bus2.wdata_i = bus1.wdata_i;

  // Small RAM models: 1-cycle and 2-cycle read latency
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  logic [7:0] rd1, rd2a, rd2;

  always @(posedge clk) begin
    if (bus1.ram_en_o) begin
      if (bus1.ram_we_o) mem1[bus1.ram_addr_o[7:0]] <= bus1.ram_wdata_o;
      else               rd1 <= mem1[bus1.ram_addr_o[7:0]];
    end
    if (bus2.ram_en_o) begin
      if (bus2.ram_we_o) mem2[bus2.ram_addr_o[7:0]] <= bus2.ram_wdata_o;
      else               rd2a <= mem2[bus2.ram_addr_o[7:0]];
    end
    rd2 <= rd2a;
  end

  assign bus1.ram_rdata_i = rd1;
  assign bus2.ram_rdata_i = rd2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic set_port(input int p, input logic r, input logic w, input logic l,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus1.req_i[p]             = r;
    bus1.we_i[p]              = w;
    bus1.lock_i[p]            = l;
    bus1.addr_i[p*AW +: AW]   = a;
    bus1.wdata_i[p*DW +: DW]  = d;
  endtask

  task automatic clear_ports();
    bus1.req_i  = '0;
    bus1.we_i   = '0;
    bus1.lock_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_ports();
    bus1.addr_i  = '0;
    bus1.wdata_i = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus1.gnt_o, bus1.rvalid_o, bus1.err_o, bus1.ram_en_o, bus1.ram_we_o, bus1.busy_o,
         bus1.ram_addr_o, bus1.ram_wdata_o, bus1.rdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_lat1: got gnt=%b rv=%b err=%b en=%b we=%b busy=%b addr=%h wd=%h rd=%h, required all 0",
               bus1.gnt_o, bus1.rvalid_o, bus1.err_o, bus1.ram_en_o, bus1.ram_we_o, bus1.busy_o,
               bus1.ram_addr_o, bus1.ram_wdata_o, bus1.rdata_o);
    end
    checks++;
    if ({bus2.gnt_o, bus2.rvalid_o, bus2.err_o, bus2.ram_en_o, bus2.ram_we_o, bus2.busy_o,
         bus2.ram_addr_o, bus2.ram_wdata_o, bus2.rdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_lat2: got gnt=%b rv=%b en=%b busy=%b, required all 0",
               bus2.gnt_o, bus2.rvalid_o, bus2.ram_en_o, bus2.busy_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    set_port(0, 1'b1, 1'b1, 1'b0, 17'd5, 8'hA5);
    #1;
    checks++; if (bus1.gnt_o !== 3'b001) begin errors++; $display("FAIL wr_gnt_lat1: got %b required 001", bus1.gnt_o); end
    checks++; if (bus2.gnt_o !== 3'b001) begin errors++; $display("FAIL wr_gnt_lat2: got %b required 001", bus2.gnt_o); end
    checks++; if (bus1.err_o !== 3'b000) begin errors++; $display("FAIL wr_err: got %b required 000", bus1.err_o); end
    @(negedge clk);
    set_port(0, 1'b0, 1'b0, 1'b0, 17'd5, 8'h00);
    set_port(2, 1'b1, 1'b0, 1'b0, 17'd5, 8'h00);
    #1;
    checks++;
    if ({bus1.ram_en_o, bus1.ram_we_o, bus1.ram_addr_o, bus1.ram_wdata_o} !== {1'b1, 1'b1, 17'd5, 8'hA5}) begin
      errors++;
      $display("FAIL wr_ram_lat1: got en=%b we=%b addr=%h wd=%h required 1 1 00005 a5",
               bus1.ram_en_o, bus1.ram_we_o, bus1.ram_addr_o, bus1.ram_wdata_o);
    end
    checks++;
    if ({bus2.ram_en_o, bus2.ram_we_o, bus2.ram_addr_o, bus2.ram_wdata_o} !== {1'b1, 1'b1, 17'd5, 8'hA5}) begin
      errors++;
      $display("FAIL wr_ram_lat2: got en=%b we=%b addr=%h wd=%h required 1 1 00005 a5",
               bus2.ram_en_o, bus2.ram_we_o, bus2.ram_addr_o, bus2.ram_wdata_o);
    end
    checks++; if (bus1.gnt_o !== 3'b100) begin errors++; $display("FAIL rd_gnt: got %b required 100", bus1.gnt_o); end
    @(negedge clk);
    set_port(2, 1'b0, 1'b0, 1'b0, 17'd5, 8'h00);
    #1;
    checks++;
    if ({bus1.ram_en_o, bus1.ram_we_o, bus1.ram_addr_o} !== {1'b1, 1'b0, 17'd5}) begin
      errors++;
      $display("FAIL rd_ram: got en=%b we=%b addr=%h required 1 0 00005", bus1.ram_en_o, bus1.ram_we_o, bus1.ram_addr_o);
    end
    checks++; if (bus1.rvalid_o !== 3'b000) begin errors++; $display("FAIL rd_early_lat1: got %b required 000", bus1.rvalid_o); end
    @(negedge clk); #1;
    checks++; if (bus1.rvalid_o !== 3'b100) begin errors++; $display("FAIL rd_valid_lat1: got %b required 100", bus1.rvalid_o); end
    checks++; if (bus1.rdata_o !== 8'hA5) begin errors++; $display("FAIL rd_data_lat1: got %h required a5", bus1.rdata_o); end
    checks++; if (bus2.rvalid_o !== 3'b000) begin errors++; $display("FAIL rd_early_lat2: got %b required 000", bus2.rvalid_o); end
    @(negedge clk); #1;
    checks++; if (bus2.rvalid_o !== 3'b100) begin errors++; $display("FAIL rd_valid_lat2: got %b required 100", bus2.rvalid_o); end
    checks++; if (bus2.rdata_o !== 8'hA5) begin errors++; $display("FAIL rd_data_lat2: got %h required a5", bus2.rdata_o); end
    checks++; if (bus1.rvalid_o !== 3'b000) begin errors++; $display("FAIL rd_once_lat1: got %b required 000", bus1.rvalid_o); end
  endtask

  task automatic test_round_robin();
    int cnt [3];
    logic [2:0] expg;
    cnt = '{0, 0, 0};
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b1, 1'b0, 17'(100 + p), 8'(p));
      #1;
      expg = 3'b001 << (k % 3);
      checks++;
      if (bus1.gnt_o !== expg) begin errors++; $display("FAIL rr_gnt[%0d]: got %b required %b", k, bus1.gnt_o, expg); end
      for (int p = 0; p < 3; p++) if (bus1.gnt_o[p]) cnt[p]++;
    end
    @(negedge clk);
    clear_ports();
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (cnt[p] != 3) begin errors++; $display("FAIL rr_count[%0d]: got %0d required 3", p, cnt[p]); end
    end
  endtask

  task automatic test_lock();
    @(negedge clk);
    clear_ports();
    set_port(1, 1'b1, 1'b0, 1'b1, 17'd20, 8'h00);
    #1;
    checks++; if (bus1.gnt_o !== 3'b010) begin errors++; $display("FAIL lock_first: got %b required 010", bus1.gnt_o); end
    for (int k = 1; k < 256; k++) begin
      @(negedge clk);
      set_port(0, 1'b1, 1'b0, 1'b0, 17'd21, 8'h00);
      set_port(2, 1'b1, 1'b0, 1'b0, 17'd22, 8'h00);
      #1;
      checks++;
      if (bus1.gnt_o !== 3'b010) begin errors++; $display("FAIL lock_gnt[%0d]: got %b required 010", k, bus1.gnt_o); end
      checks++;
      if (bus1.busy_o !== 1'b1) begin errors++; $display("FAIL lock_busy[%0d]: got %b required 1", k, bus1.busy_o); end
    end
    @(negedge clk); #1;
    checks++; if (bus1.gnt_o !== 3'b100) begin errors++; $display("FAIL lock_release_p2: got %b required 100", bus1.gnt_o); end
    checks++; if (bus1.busy_o !== 1'b1) begin errors++; $display("FAIL lock_release_busy: got %b required 1", bus1.busy_o); end
    @(negedge clk);
    set_port(2, 1'b0, 1'b0, 1'b0, 17'd22, 8'h00);
    #1;
    checks++; if (bus1.gnt_o !== 3'b001) begin errors++; $display("FAIL lock_then_p0: got %b required 001", bus1.gnt_o); end
    @(negedge clk);
    set_port(0, 1'b0, 1'b0, 1'b0, 17'd21, 8'h00);
    #1;
    checks++; if (bus1.gnt_o !== 3'b010) begin errors++; $display("FAIL lock_then_p1: got %b required 010", bus1.gnt_o); end
    @(negedge clk);
    clear_ports();
    #1;
    checks++; if (bus1.gnt_o !== 3'b000) begin errors++; $display("FAIL lock_idle: got %b required 000", bus1.gnt_o); end
    repeat (4) @(negedge clk);
    #1;
    checks++; if (bus1.busy_o !== 1'b0) begin errors++; $display("FAIL lock_drained_lat1: got %b required 0", bus1.busy_o); end
    checks++; if (bus2.busy_o !== 1'b0) begin errors++; $display("FAIL lock_drained_lat2: got %b required 0", bus2.busy_o); end
  endtask

  task automatic test_oor();
    @(negedge clk);
    set_port(2, 1'b1, 1'b0, 1'b0, 17'd76800, 8'h00);
    #1;
    checks++; if (bus1.gnt_o !== 3'b100) begin errors++; $display("FAIL oor_gnt: got %b required 100", bus1.gnt_o); end
    checks++; if (bus1.err_o !== 3'b100) begin errors++; $display("FAIL oor_err_lat1: got %b required 100", bus1.err_o); end
    checks++; if (bus2.err_o !== 3'b100) begin errors++; $display("FAIL oor_err_lat2: got %b required 100", bus2.err_o); end
    @(negedge clk);
    clear_ports();
    #1;
    checks++; if (bus1.ram_en_o !== 1'b0) begin errors++; $display("FAIL oor_en_lat1: got %b required 0", bus1.ram_en_o); end
    checks++; if (bus2.ram_en_o !== 1'b0) begin errors++; $display("FAIL oor_en_lat2: got %b required 0", bus2.ram_en_o); end
    checks++; if (bus1.err_o !== 3'b000) begin errors++; $display("FAIL oor_err_pulse: got %b required 000", bus1.err_o); end
    @(negedge clk); #1;
    checks++;
    if ({bus1.rvalid_o, bus1.rdata_o} !== {3'b100, 8'h00}) begin
      errors++; $display("FAIL oor_rsp_lat1: got rv=%b rd=%h required 100 00", bus1.rvalid_o, bus1.rdata_o);
    end
    @(negedge clk); #1;
    checks++;
    if ({bus2.rvalid_o, bus2.rdata_o} !== {3'b100, 8'h00}) begin
      errors++; $display("FAIL oor_rsp_lat2: got rv=%b rd=%h required 100 00", bus2.rvalid_o, bus2.rdata_o);
    end
    // Last valid address must not trap
    @(negedge clk);
    set_port(0, 1'b1, 1'b1, 1'b0, 17'd76799, 8'h5A);
    #1;
    checks++;
    if ({bus1.gnt_o, bus1.err_o} !== {3'b001, 3'b000}) begin
      errors++; $display("FAIL edge_gnt_err: got gnt=%b err=%b required 001 000", bus1.gnt_o, bus1.err_o);
    end
    @(negedge clk);
    clear_ports();
    #1;
    checks++;
    if ({bus1.ram_en_o, bus1.ram_addr_o} !== {1'b1, 17'd76799}) begin
      errors++; $display("FAIL edge_ram: got en=%b addr=%0d required 1 76799", bus1.ram_en_o, bus1.ram_addr_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] expg, exp1, exp2;
    logic [7:0] d1, d2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_port(0, 1'b1, 1'b1, 1'b0, 17'(10 + i), 8'(17 * (i + 1)));
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      clear_ports();
      if (c < 3) set_port(c, 1'b1, 1'b0, 1'b0, 17'(10 + c), 8'h00);
      #1;
      expg = (c < 3) ? (3'b001 << c) : 3'b000;
      exp1 = (c >= 2 && c <= 4) ? (3'b001 << (c - 2)) : 3'b000;
      exp2 = (c >= 3 && c <= 5) ? (3'b001 << (c - 3)) : 3'b000;
      d1   = 8'(17 * (c - 1));
      d2   = 8'(17 * (c - 2));
      checks++;
      if (bus1.gnt_o !== expg) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b required %b", c, bus1.gnt_o, expg); end
      checks++;
      if (bus1.rvalid_o !== exp1) begin errors++; $display("FAIL b2b_rv_lat1[%0d]: got %b required %b", c, bus1.rvalid_o, exp1); end
      if (exp1 != 3'b000) begin
        checks++;
        if (bus1.rdata_o !== d1) begin errors++; $display("FAIL b2b_rd_lat1[%0d]: got %h required %h", c, bus1.rdata_o, d1); end
      end
      checks++;
      if (bus2.rvalid_o !== exp2) begin errors++; $display("FAIL b2b_rv_lat2[%0d]: got %b required %b", c, bus2.rvalid_o, exp2); end
      if (exp2 != 3'b000) begin
        checks++;
        if (bus2.rdata_o !== d2) begin errors++; $display("FAIL b2b_rd_lat2[%0d]: got %h required %h", c, bus2.rdata_o, d2); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    clear_ports();
    set_port(1, 1'b1, 1'b0, 1'b0, 17'd11, 8'h00);
    @(negedge clk);
    clear_ports();
    set_port(0, 1'b1, 1'b0, 1'b0, 17'd10, 8'h00);
    @(negedge clk);
    clear_ports();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus1.rvalid_o, bus1.ram_en_o, bus1.busy_o} !== 5'b0) begin
      errors++; $display("FAIL rst_cycle_lat1: got rv=%b en=%b busy=%b required 000 0 0", bus1.rvalid_o, bus1.ram_en_o, bus1.busy_o);
    end
    checks++;
    if ({bus2.rvalid_o, bus2.ram_en_o, bus2.busy_o} !== 5'b0) begin
      errors++; $display("FAIL rst_cycle_lat2: got rv=%b en=%b busy=%b required 000 0 0", bus2.rvalid_o, bus2.ram_en_o, bus2.busy_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus1.gnt_o, bus1.rvalid_o, bus1.err_o, bus1.ram_en_o, bus1.ram_we_o, bus1.busy_o,
         bus1.ram_addr_o, bus1.ram_wdata_o, bus1.rdata_o} !== '0) begin
      errors++; $display("FAIL rst_after_lat1: got rv=%b en=%b busy=%b addr=%h required all 0",
                         bus1.rvalid_o, bus1.ram_en_o, bus1.busy_o, bus1.ram_addr_o);
    end
    checks++;
    if ({bus2.gnt_o, bus2.rvalid_o, bus2.err_o, bus2.ram_en_o, bus2.ram_we_o, bus2.busy_o,
         bus2.ram_addr_o, bus2.ram_wdata_o, bus2.rdata_o} !== '0) begin
      errors++; $display("FAIL rst_after_lat2: got rv=%b en=%b busy=%b addr=%h required all 0",
                         bus2.rvalid_o, bus2.ram_en_o, bus2.busy_o, bus2.ram_addr_o);
    end
    @(negedge clk); #1;
    checks++;
    if ({bus1.rvalid_o, bus2.rvalid_o} !== 6'b0) begin
      errors++; $display("FAIL rst_no_late_rv: got %b/%b required 000/000", bus1.rvalid_o, bus2.rvalid_o);
    end
    @(negedge clk);
    for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b0, 1'b0, 17'(10 + p), 8'h00);
    #1;
    checks++; if (bus1.gnt_o !== 3'b001) begin errors++; $display("FAIL rst_first_gnt_lat1: got %b required 001", bus1.gnt_o); end
    checks++; if (bus2.gnt_o !== 3'b001) begin errors++; $display("FAIL rst_first_gnt_lat2: got %b required 001", bus2.gnt_o); end
    @(negedge clk);
    clear_ports();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus1.req_i   = '0;
    bus1.we_i    = '0;
    bus1.lock_i  = '0;
    bus1.addr_i  = '0;
    bus1.wdata_i = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_lock();
    test_oor();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
